// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: sequencer for the two-layer fully-connected TPU datapath.
// A start request walks layer 1 and then layer 2. Each layer is processed in
// passes of LANES neurons. For every pass, the block clears the accumulators,
// streams IN multiply-accumulate steps, adds the bias and writes the result back.
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst         synchronous active-low reset
//   i_start       inference request, sampled only while idle
//   o_ready       high only while idle
//   o_done        one-cycle pulse after the layer-2 write-back
//   o_layer_sel   0 = layer 1, 1 = layer 2
//   o_acc_clr     clear all lane accumulators
//   o_acc_en      accumulate in_data[o_in_addr] * weight[o_w_addr]
//   o_in_addr     input-vector index k
//   o_w_addr      weight address, pass*IN + k
//   o_bias_en     add bias word o_b_addr
//   o_b_addr      bias address (pass index)
//   o_wb_en       write lane results into result word o_wb_addr
//   o_wb_addr     result-word index (pass index)
//   o_lane_mask   valid lanes of the current pass
//   o_cycle_cnt   busy-cycle counter, only when TPU_SEQ_PERF_EN is defined
//
// Optional feature macro: TPU_SEQ_PERF_EN (adds o_cycle_cnt).
module tpu_seq_ctrl #(
  parameter int LANES  = 8,
  parameter int L1_IN  = 62,
  parameter int L1_OUT = 30,
  parameter int L2_OUT = 10,
  parameter int AW     = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_layer_sel,
  output logic             o_acc_clr,
  output logic             o_acc_en,
  output logic [7:0]       o_in_addr,
  output logic [AW-1:0]    o_w_addr,
  output logic             o_bias_en,
  output logic [3:0]       o_b_addr,
  output logic             o_wb_en,
  output logic [3:0]       o_wb_addr,
  output logic [LANES-1:0] o_lane_mask
`ifdef TPU_SEQ_PERF_EN
  ,
  output logic [15:0]      o_cycle_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_BIAS, S_WB, S_DONE} state_t;

  localparam logic [7:0] IN1  = 8'(L1_IN);
  localparam logic [7:0] IN2  = 8'(L1_OUT);
  localparam logic [7:0] OUT1 = 8'(L1_OUT);
  localparam logic [7:0] OUT2 = 8'(L2_OUT);
  localparam logic [3:0] NP1  = 4'((L1_OUT + LANES - 1) / LANES);
  localparam logic [3:0] NP2  = 4'((L2_OUT + LANES - 1) / LANES);

  state_t           r_state, w_nextState;
  logic [7:0]       r_k, w_nextK;
  logic [3:0]       r_pass, w_nextPass;
  logic             r_layer, w_nextLayer;

  logic [7:0]       w_curIn;
  logic [3:0]       w_curNpass;
  logic [7:0]       w_nextIn;
  logic [7:0]       w_nextOut;
  logic [3:0]       w_nextNpass;
  logic [AW-1:0]    w_wAddr;
  logic [LANES-1:0] w_nextMask;
  logic             w_inPass;

  assign w_curIn     = r_layer ? IN2 : IN1;
  assign w_curNpass  = r_layer ? NP2 : NP1;
  assign w_nextIn    = w_nextLayer ? IN2 : IN1;
  assign w_nextOut   = w_nextLayer ? OUT2 : OUT1;
  assign w_nextNpass = w_nextLayer ? NP2 : NP1;

  // Next-state logic for the phase, the input index and the pass/layer position.
  always_comb begin
    w_nextState = r_state;
    w_nextK     = r_k;
    w_nextPass  = r_pass;
    w_nextLayer = r_layer;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState = S_CLR;
          w_nextK     = '0;
          w_nextPass  = '0;
          w_nextLayer = 1'b0;
        end
      end
      S_CLR: begin
        w_nextState = S_MAC;
        w_nextK     = '0;
      end
      S_MAC: begin
        if (r_k == w_curIn - 8'd1) begin
          w_nextState = S_BIAS;
        end else begin
          w_nextK = r_k + 8'd1;
        end
      end
      S_BIAS: w_nextState = S_WB;
      S_WB: begin
        if (r_pass < w_curNpass - 4'd1) begin
          w_nextState = S_CLR;
          w_nextPass  = r_pass + 4'd1;
        end else if (!r_layer) begin
          w_nextState = S_CLR;
          w_nextLayer = 1'b1;
          w_nextPass  = '0;
        end else begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
        w_nextLayer = 1'b0;
        w_nextPass  = '0;
        w_nextK     = '0;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output values are derived from the next state so that every output is a
  // flop aligned with the state it describes. The lane mask trims the surplus
  // lanes of the final pass and stays constant for the whole pass.
  always_comb begin
    w_wAddr    = AW'(w_nextPass) * AW'(w_nextIn) + AW'(w_nextK);
    w_inPass   = (w_nextState == S_CLR) || (w_nextState == S_MAC) ||
                 (w_nextState == S_BIAS) || (w_nextState == S_WB);
    w_nextMask = '0;
    if (w_inPass) begin
      for (int i = 0; i < LANES; i++) begin
        w_nextMask[i] = (w_nextPass != w_nextNpass - 4'd1) ||
                        ((int'(w_nextPass) * LANES + i) < int'(w_nextOut));
      end
    end
  end

  // State and output registers; a low reset aborts any run immediately.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_pass      <= '0;
      r_layer     <= 1'b0;
      o_ready     <= 1'b1;
      o_done      <= 1'b0;
      o_layer_sel <= 1'b0;
      o_acc_clr   <= 1'b0;
      o_acc_en    <= 1'b0;
      o_in_addr   <= '0;
      o_w_addr    <= '0;
      o_bias_en   <= 1'b0;
      o_b_addr    <= '0;
      o_wb_en     <= 1'b0;
      o_wb_addr   <= '0;
      o_lane_mask <= '0;
    end else begin
      r_state     <= w_nextState;
      r_k         <= w_nextK;
      r_pass      <= w_nextPass;
      r_layer     <= w_nextLayer;
      o_ready     <= (w_nextState == S_IDLE);
      o_done      <= (w_nextState == S_DONE);
      o_layer_sel <= w_nextLayer;
      o_acc_clr   <= (w_nextState == S_CLR);
      o_acc_en    <= (w_nextState == S_MAC);
      o_in_addr   <= (w_nextState == S_MAC) ? w_nextK : 8'd0;
      o_w_addr    <= (w_nextState == S_MAC) ? w_wAddr : '0;
      o_bias_en   <= (w_nextState == S_BIAS);
      o_b_addr    <= (w_nextState == S_BIAS) ? w_nextPass : 4'd0;
      o_wb_en     <= (w_nextState == S_WB);
      o_wb_addr   <= (w_nextState == S_WB) ? w_nextPass : 4'd0;
      o_lane_mask <= w_nextMask;
    end
  end

`ifdef TPU_SEQ_PERF_EN
  logic [15:0] r_cycleCnt;

  // Busy-cycle counter: restarts with each accepted start and then freezes in
  // idle, so it reports the length of the last run.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cycleCnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_start) begin
        r_cycleCnt <= '0;
      end
    end else begin
      r_cycleCnt <= r_cycleCnt + 16'd1;
    end
  end

  assign o_cycle_cnt = r_cycleCnt;
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb_tpu_seq_ctrl: self-checking bench for tpu_seq_ctrl.
// The bench builds the expected per-cycle behaviour of a full inference from
// nested layer/pass/index loops. It compares the DUT against that trace and
// adds randomized start noise, randomized abort points and back-to-back runs.
module tb_tpu_seq_ctrl;

  localparam int LANES  = 8;
  localparam int L1_IN  = 62;
  localparam int L1_OUT = 30;
  localparam int L2_OUT = 10;
  localparam int AW     = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             ready, done, layerSel, accClr, accEn, biasEn, wbEn;
  logic [7:0]       inAddr;
  logic [AW-1:0]    wAddr;
  logic [3:0]       bAddr, wbAddr;
  logic [LANES-1:0] laneMask;
`ifdef TPU_SEQ_PERF_EN
  logic [15:0]      cycleCnt;
`endif

  int nCompared = 0;
  int nMismatched = 0;

  tpu_seq_ctrl #(.LANES(LANES), .L1_IN(L1_IN), .L1_OUT(L1_OUT), .L2_OUT(L2_OUT), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_ready(ready), .o_done(done), .o_layer_sel(layerSel),
    .o_acc_clr(accClr), .o_acc_en(accEn), .o_in_addr(inAddr), .o_w_addr(wAddr),
    .o_bias_en(biasEn), .o_b_addr(bAddr), .o_wb_en(wbEn), .o_wb_addr(wbAddr),
    .o_lane_mask(laneMask)
`ifdef TPU_SEQ_PERF_EN
    , .o_cycle_cnt(cycleCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             ready;
    logic             done;
    logic             layerSel;
    logic             accClr;
    logic             accEn;
    logic [7:0]       inAddr;
    logic [AW-1:0]    wAddr;
    logic             biasEn;
    logic [3:0]       bAddr;
    logic             wbEn;
    logic [3:0]       wbAddr;
    logic [LANES-1:0] laneMask;
  } obs_t;

  obs_t expQ[$];
  obs_t careQ[$];
  int   expAccCycles;
  int   expWbCount;

  task automatic sample(output obs_t a);
    a = '0;
    a.ready = ready; a.done = done; a.layerSel = layerSel;
    a.accClr = accClr; a.accEn = accEn; a.inAddr = inAddr; a.wAddr = wAddr;
    a.biasEn = biasEn; a.bAddr = bAddr; a.wbEn = wbEn; a.wbAddr = wbAddr;
    a.laneMask = laneMask;
  endtask

  // Reference trace of one inference, one entry per cycle, with a mask of the
  // fields that are defined in that cycle.
  task automatic build_trace();
    obs_t e, m, base;
    expQ.delete();
    careQ.delete();
    expAccCycles = 0;
    expWbCount = 0;
    base = '0;
    base.ready = 1'b1; base.done = 1'b1; base.layerSel = 1'b1; base.accClr = 1'b1;
    base.accEn = 1'b1; base.biasEn = 1'b1; base.wbEn = 1'b1; base.laneMask = '1;
    for (int layer = 0; layer < 2; layer++) begin
      int nIn, nOut, nPass;
      nIn   = (layer == 0) ? L1_IN : L1_OUT;
      nOut  = (layer == 0) ? L1_OUT : L2_OUT;
      nPass = (nOut + LANES - 1) / LANES;
      for (int p = 0; p < nPass; p++) begin
        logic [LANES-1:0] mask;
        for (int i = 0; i < LANES; i++) mask[i] = (p * LANES + i) < nOut;
        e = '0; e.layerSel = 1'(layer); e.laneMask = mask;
        e.accClr = 1'b1; expQ.push_back(e); careQ.push_back(base);
        for (int k = 0; k < nIn; k++) begin
          e = '0; e.layerSel = 1'(layer); e.laneMask = mask;
          e.accEn = 1'b1; e.inAddr = 8'(k); e.wAddr = AW'(p * nIn + k);
          m = base; m.inAddr = '1; m.wAddr = '1;
          expQ.push_back(e); careQ.push_back(m);
          expAccCycles++;
        end
        e = '0; e.layerSel = 1'(layer); e.laneMask = mask;
        e.biasEn = 1'b1; e.bAddr = 4'(p);
        m = base; m.bAddr = '1;
        expQ.push_back(e); careQ.push_back(m);
        e = '0; e.layerSel = 1'(layer); e.laneMask = mask;
        e.wbEn = 1'b1; e.wbAddr = 4'(p);
        m = base; m.wbAddr = '1;
        expQ.push_back(e); careQ.push_back(m);
        expWbCount++;
      end
    end
    e = '0; e.done = 1'b1;
    m = '0; m.ready = 1'b1; m.done = 1'b1; m.accClr = 1'b1; m.accEn = 1'b1;
    m.biasEn = 1'b1; m.wbEn = 1'b1;
    expQ.push_back(e); careQ.push_back(m);
  endtask

  function automatic obs_t idle_values();
    obs_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Runs one inference from a start pulse and checks every cycle plus the
  // idle cycle that follows. With noisyStart, random start pulses (including
  // one in the done cycle) must be ignored. With holdStart, start stays high
  // so the next run begins straight from the returning idle cycle.
  task automatic check_run(input string tag, input bit noisyStart, input bit holdStart);
    obs_t a, e, m;
    int accCount, wbCount, doneCount, doneCycle;
    logic [4:0] wbSeen[$];
    logic [4:0] wbExp[$];
    build_trace();
    accCount = 0; wbCount = 0; doneCount = 0; doneCycle = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!holdStart) start = 1'b0;
    for (int c = 1; c <= expQ.size(); c++) begin
      sample(a);
      e = expQ[c-1];
      m = careQ[c-1];
      nCompared++;
      if ((a & m) !== (e & m)) begin
        nMismatched++;
        $display("[TB] FAIL %s trace cycle %0d: got %h required %h (care %h)", tag, c, a, e, m);
      end
      if (a.accEn) accCount++;
      if (a.wbEn) begin wbCount++; wbSeen.push_back({a.layerSel, a.wbAddr}); end
      if (a.done) begin doneCount++; doneCycle = c; end
      if (noisyStart && !holdStart)
        start = ($urandom_range(0, 3) == 0) || (c == expQ.size());
      @(posedge clk); #1;
    end
    if (!holdStart) start = 1'b0;
    sample(a);
    nCompared++;
    if (a.ready !== 1'b1 || a.done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s ready after done: got ready=%b done=%b required ready=1 done=0", tag, a.ready, a.done);
    end
    nCompared++;
    if (accCount != expAccCycles) begin
      nMismatched++;
      $display("[TB] FAIL %s acc_en cycles: got %0d required %0d", tag, accCount, expAccCycles);
    end
    nCompared++;
    if (doneCount != 1 || doneCycle != expQ.size()) begin
      nMismatched++;
      $display("[TB] FAIL %s done: got %0d pulses at cycle %0d required 1 at cycle %0d", tag, doneCount, doneCycle, expQ.size());
    end
    for (int p = 0; p < (L1_OUT + LANES - 1) / LANES; p++) wbExp.push_back({1'b0, 4'(p)});
    for (int p = 0; p < (L2_OUT + LANES - 1) / LANES; p++) wbExp.push_back({1'b1, 4'(p)});
    nCompared++;
    if (wbCount != expWbCount || wbSeen != wbExp) begin
      nMismatched++;
      $display("[TB] FAIL %s write-back sequence: got %0d pulses required %0d (layer/addr order differs or count)", tag, wbCount, expWbCount);
    end
`ifdef TPU_SEQ_PERF_EN
    nCompared++;
    if (cycleCnt !== 16'(expQ.size())) begin
      nMismatched++;
      $display("[TB] FAIL %s cycle_cnt: got %0d required %0d", tag, cycleCnt, expQ.size());
    end
`endif
  endtask

  task automatic test_reset();
    obs_t a, e;
    int doneSeen;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    e = idle_values();
    sample(a);
    nCompared++;
    if (a !== e) begin
      nMismatched++;
      $display("[TB] FAIL reset values: got %h required %h", a, e);
    end
`ifdef TPU_SEQ_PERF_EN
    nCompared++;
    if (cycleCnt !== 16'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset cycle_cnt: got %0d required 0", cycleCnt);
    end
`endif
    doneSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      sample(a);
      if (a.done) doneSeen++;
      nCompared++;
      if (a !== e) begin
        nMismatched++;
        $display("[TB] FAIL idle hold cycle %0d: got %h required %h", c, a, e);
      end
    end
    nCompared++;
    if (doneSeen != 0) begin
      nMismatched++;
      $display("[TB] FAIL idle done pulses: got %0d required 0", doneSeen);
    end
  endtask

  task automatic test_single_run();
    check_run("single_run", 1'b0, 1'b0);
  endtask

  task automatic test_ignored_starts();
    check_run("ignored_starts", 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    obs_t a, e;
    int abortAt, wbAfter, accAfter;
    abortAt = int'($urandom_range(90, 110));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < abortAt; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    e = idle_values();
    sample(a);
    nCompared++;
    if (a !== e) begin
      nMismatched++;
      $display("[TB] FAIL mid-run reset at cycle %0d: got %h required %h", abortAt, a, e);
    end
    wbAfter = 0; accAfter = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (wbEn) wbAfter++;
      if (accEn) accAfter++;
    end
    nCompared++;
    if (wbAfter != 0 || accAfter != 0 || ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL activity after reset: got wb=%0d acc=%0d ready=%b required 0 0 1", wbAfter, accAfter, ready);
    end
    check_run("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    check_run("back_to_back_a", 1'b0, 1'b1);
    check_run("back_to_back_b", 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_run();
    repeat (int'($urandom_range(1, 5))) @(posedge clk);
    #1;
    test_ignored_starts();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
